// File: rtl/vregfile_wb_arbiter.sv
// vregfile_wb_arbiter
//
// Write-port arbiter and busy scoreboard for the vector register file.
// Two producers (vector ALU, vector LSU) compete for the single regfile
// write port. One request is granted per cycle using round-robin, and the
// granted write is driven to the regfile through a registered stage. A
// per-register busy bitmap tracks outstanding writes so that the issue stage
// can stall on RAW/WAW hazards.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   alu_valid_i/ready_o      ALU writeback handshake
//   alu_vrd_addr_i/data_i    ALU destination register and data
//   lsu_valid_i/ready_o      LSU writeback handshake
//   lsu_vrd_addr_i/data_i    LSU destination register and data
//   issue_valid_i            an issuing instruction will write issue_vrd_addr_i
//   issue_vrd_addr_i         destination register of the issuing instruction
//   vregw_en_o               registered regfile write enable
//   vrd_addr_o, vrd_data_o   registered regfile write address / data
//   busy_o                   bit i set while register i has a pending write
module vregfile_wb_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ELEMENTS   = 8,
   parameter int VLEN       = DATA_WIDTH * ELEMENTS,
   parameter int VREGS      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alu_valid_i,
   output logic             alu_ready_o,
   input  logic [4:0]       alu_vrd_addr_i,
   input  logic [VLEN-1:0]  alu_vrd_data_i,
   input  logic             lsu_valid_i,
   output logic             lsu_ready_o,
   input  logic [4:0]       lsu_vrd_addr_i,
   input  logic [VLEN-1:0]  lsu_vrd_data_i,
   input  logic             issue_valid_i,
   input  logic [4:0]       issue_vrd_addr_i,
   output logic             vregw_en_o,
   output logic [4:0]       vrd_addr_o,
   output logic [VLEN-1:0]  vrd_data_o,
   output logic [VREGS-1:0] busy_o
);

   typedef enum logic {
      PRI_ALU = 1'b0,
      PRI_LSU = 1'b1
   } pri_e;

   pri_e             ptr_q, ptr_d;
   logic             vregw_en_q, vregw_en_d;
   logic [4:0]       vrd_addr_q, vrd_addr_d;
   logic [VLEN-1:0]  vrd_data_q, vrd_data_d;
   logic [VREGS-1:0] busy_q, busy_d;

   logic             alu_grant_s;
   logic             lsu_grant_s;
   logic             any_grant_s;
   logic [4:0]       sel_addr_s;
   logic [VLEN-1:0]  sel_data_s;

   // Round-robin grant; rst masks grants so requests seen during reset are refused.
   always_comb begin
      alu_grant_s = 1'b0;
      lsu_grant_s = 1'b0;
      if (rst) begin
         alu_grant_s = 1'b0;
         lsu_grant_s = 1'b0;
      end else if (alu_valid_i && lsu_valid_i) begin
         case (ptr_q)
            PRI_ALU: alu_grant_s = 1'b1;
            PRI_LSU: lsu_grant_s = 1'b1;
            default: alu_grant_s = 1'b1;
         endcase
      end else begin
         alu_grant_s = alu_valid_i;
         lsu_grant_s = lsu_valid_i;
      end
   end

   // Winner mux, pointer advance, output stage next state and scoreboard update.
   always_comb begin
      any_grant_s = alu_grant_s | lsu_grant_s;
      ptr_d       = ptr_q;
      sel_addr_s  = alu_vrd_addr_i;
      sel_data_s  = alu_vrd_data_i;
      vregw_en_d  = 1'b0;
      vrd_addr_d  = vrd_addr_q;
      vrd_data_d  = vrd_data_q;
      busy_d      = busy_q;

      if (lsu_grant_s) begin
         sel_addr_s = lsu_vrd_addr_i;
         sel_data_s = lsu_vrd_data_i;
      end else begin
         sel_addr_s = alu_vrd_addr_i;
         sel_data_s = alu_vrd_data_i;
      end

      if (alu_grant_s) begin
         ptr_d = PRI_LSU;
      end else if (lsu_grant_s) begin
         ptr_d = PRI_ALU;
      end else begin
         ptr_d = ptr_q;
      end

      // v0 is hardwired: the transfer is accepted but never written or tracked.
      if (any_grant_s && (sel_addr_s != 5'd0)) begin
         vregw_en_d         = 1'b1;
         vrd_addr_d         = sel_addr_s;
         vrd_data_d         = sel_data_s;
         busy_d[sel_addr_s] = 1'b0;
      end else begin
         vregw_en_d = 1'b0;
      end

      // Set is applied after clear so a new producer wins over a retiring one.
      if (issue_valid_i && (issue_vrd_addr_i != 5'd0)) begin
         busy_d[issue_vrd_addr_i] = 1'b1;
      end else begin
         busy_d = busy_d;
      end
   end

   // State registers; reset clears everything, including an in-flight write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q      <= PRI_ALU;
         vregw_en_q <= 1'b0;
         vrd_addr_q <= 5'd0;
         vrd_data_q <= {VLEN{1'b0}};
         busy_q     <= {VREGS{1'b0}};
      end else begin
         ptr_q      <= ptr_d;
         vregw_en_q <= vregw_en_d;
         vrd_addr_q <= vrd_addr_d;
         vrd_data_q <= vrd_data_d;
         busy_q     <= busy_d;
      end
   end

   assign alu_ready_o = alu_grant_s;
   assign lsu_ready_o = lsu_grant_s;
   assign vregw_en_o  = vregw_en_q;
   assign vrd_addr_o  = vrd_addr_q;
   assign vrd_data_o  = vrd_data_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_vregfile_wb_arbiter.sv
// Directed self-checking bench for vregfile_wb_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_vregfile_wb_arbiter;
   localparam int VLEN  = 256;
   localparam int VREGS = 32;

   logic             clk;
   logic             rst;
   logic             alu_valid_i;
   logic             alu_ready_o;
   logic [4:0]       alu_vrd_addr_i;
   logic [VLEN-1:0]  alu_vrd_data_i;
   logic             lsu_valid_i;
   logic             lsu_ready_o;
   logic [4:0]       lsu_vrd_addr_i;
   logic [VLEN-1:0]  lsu_vrd_data_i;
   logic             issue_valid_i;
   logic [4:0]       issue_vrd_addr_i;
   logic             vregw_en_o;
   logic [4:0]       vrd_addr_o;
   logic [VLEN-1:0]  vrd_data_o;
   logic [VREGS-1:0] busy_o;

   int errors;
   int checks;

   localparam logic [VLEN-1:0] DATA_A = {8{32'h11111111}};
   localparam logic [VLEN-1:0] DATA_B = {8{32'h22222222}};
   localparam logic [VLEN-1:0] DATA_D = {8{32'hDEADBEEF}};
   localparam logic [VLEN-1:0] DATA_C = {8{32'hCAFEF00D}};

   vregfile_wb_arbiter dut (
      .clk              (clk),
      .rst              (rst),
      .alu_valid_i      (alu_valid_i),
      .alu_ready_o      (alu_ready_o),
      .alu_vrd_addr_i   (alu_vrd_addr_i),
      .alu_vrd_data_i   (alu_vrd_data_i),
      .lsu_valid_i      (lsu_valid_i),
      .lsu_ready_o      (lsu_ready_o),
      .lsu_vrd_addr_i   (lsu_vrd_addr_i),
      .lsu_vrd_data_i   (lsu_vrd_data_i),
      .issue_valid_i    (issue_valid_i),
      .issue_vrd_addr_i (issue_vrd_addr_i),
      .vregw_en_o       (vregw_en_o),
      .vrd_addr_o       (vrd_addr_o),
      .vrd_data_o       (vrd_data_o),
      .busy_o           (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid_i      = 1'b0;
      lsu_valid_i      = 1'b0;
      issue_valid_i    = 1'b0;
      alu_vrd_addr_i   = 5'd0;
      lsu_vrd_addr_i   = 5'd0;
      issue_vrd_addr_i = 5'd0;
      alu_vrd_data_i   = {VLEN{1'b0}};
      lsu_vrd_data_i   = {VLEN{1'b0}};
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      alu_valid_i    = 1'b1;
      alu_vrd_addr_i = 5'd3;
      alu_vrd_data_i = DATA_A;
      lsu_valid_i    = 1'b1;
      lsu_vrd_addr_i = 5'd4;
      lsu_vrd_data_i = DATA_B;
      tick();
      tick();
      checks++; if (alu_ready_o !== 1'b0) begin errors++; $display("FAIL reset_alu_ready got=%b exp=0", alu_ready_o); end
      checks++; if (lsu_ready_o !== 1'b0) begin errors++; $display("FAIL reset_lsu_ready got=%b exp=0", lsu_ready_o); end
      checks++; if (vregw_en_o !== 1'b0) begin errors++; $display("FAIL reset_wen got=%b exp=0", vregw_en_o); end
      checks++; if (busy_o !== 32'h0) begin errors++; $display("FAIL reset_busy got=%h exp=0", busy_o); end
      checks++; if (vrd_addr_o !== 5'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", vrd_addr_o); end
      checks++; if (vrd_data_o !== {VLEN{1'b0}}) begin errors++; $display("FAIL reset_data got=%h exp=0", vrd_data_o); end
      rst = 1'b0;
      #1;
      checks++; if ({alu_ready_o, lsu_ready_o} !== 2'b10) begin errors++; $display("FAIL reset_first_grant got=%b exp=10", {alu_ready_o, lsu_ready_o}); end
      tick();
      checks++; if (vregw_en_o !== 1'b1 || vrd_addr_o !== 5'd3) begin errors++; $display("FAIL reset_first_write got en=%b addr=%0d exp en=1 addr=3", vregw_en_o, vrd_addr_o); end
      idle_inputs();
      tick();
      checks++; if (vregw_en_o !== 1'b0) begin errors++; $display("FAIL reset_idle_wen got=%b exp=0", vregw_en_o); end
   endtask

   task automatic test_single();
      alu_valid_i    = 1'b1;
      alu_vrd_addr_i = 5'd5;
      alu_vrd_data_i = DATA_A;
      #1;
      checks++; if (alu_ready_o !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", alu_ready_o); end
      checks++; if (vregw_en_o !== 1'b0) begin errors++; $display("FAIL single_no_early_wen got=%b exp=0", vregw_en_o); end
      tick();
      idle_inputs();
      checks++; if (vregw_en_o !== 1'b1) begin errors++; $display("FAIL single_wen got=%b exp=1", vregw_en_o); end
      checks++; if (vrd_addr_o !== 5'd5) begin errors++; $display("FAIL single_addr got=%0d exp=5", vrd_addr_o); end
      checks++; if (vrd_data_o !== DATA_A) begin errors++; $display("FAIL single_data got=%h exp=%h", vrd_data_o, DATA_A); end
      tick();
      checks++; if (vregw_en_o !== 1'b0) begin errors++; $display("FAIL single_wen_drop got=%b exp=0", vregw_en_o); end
      checks++; if (vrd_addr_o !== 5'd5 || vrd_data_o !== DATA_A) begin errors++; $display("FAIL single_hold got addr=%0d exp=5", vrd_addr_o); end
   endtask

   // Pointer is at LSU here (last grant was ALU).
   task automatic test_v0();
      lsu_valid_i    = 1'b1;
      lsu_vrd_addr_i = 5'd0;
      lsu_vrd_data_i = DATA_D;
      #1;
      checks++; if (lsu_ready_o !== 1'b1) begin errors++; $display("FAIL v0_ready got=%b exp=1", lsu_ready_o); end
      tick();
      idle_inputs();
      checks++; if (vregw_en_o !== 1'b0) begin errors++; $display("FAIL v0_wen got=%b exp=0", vregw_en_o); end
      checks++; if (busy_o !== 32'h0) begin errors++; $display("FAIL v0_busy got=%h exp=0", busy_o); end
   endtask

   // Pointer is at ALU here (advanced by the v0 transfer).
   task automatic test_round_robin();
      logic [1:0] exp_rdy [4];
      logic [4:0] exp_addr [4];
      exp_rdy[0] = 2'b10; exp_rdy[1] = 2'b01; exp_rdy[2] = 2'b10; exp_rdy[3] = 2'b01;
      exp_addr[0] = 5'd3; exp_addr[1] = 5'd4; exp_addr[2] = 5'd3; exp_addr[3] = 5'd4;
      alu_valid_i    = 1'b1;
      alu_vrd_addr_i = 5'd3;
      alu_vrd_data_i = DATA_A;
      lsu_valid_i    = 1'b1;
      lsu_vrd_addr_i = 5'd4;
      lsu_vrd_data_i = DATA_B;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if ({alu_ready_o, lsu_ready_o} !== exp_rdy[i]) begin errors++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, {alu_ready_o, lsu_ready_o}, exp_rdy[i]); end
         tick();
         checks++; if (vregw_en_o !== 1'b1 || vrd_addr_o !== exp_addr[i]) begin errors++; $display("FAIL rr_write[%0d] got en=%b addr=%0d exp en=1 addr=%0d", i, vregw_en_o, vrd_addr_o, exp_addr[i]); end
         checks++; if (vrd_data_o !== ((exp_addr[i] == 5'd3) ? DATA_A : DATA_B)) begin errors++; $display("FAIL rr_data[%0d] got=%h", i, vrd_data_o); end
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_scoreboard();
      issue_valid_i    = 1'b1;
      issue_vrd_addr_i = 5'd7;
      tick();
      idle_inputs();
      checks++; if (busy_o !== 32'h0000_0080) begin errors++; $display("FAIL sb_set got=%h exp=00000080", busy_o); end
      issue_valid_i    = 1'b1;
      issue_vrd_addr_i = 5'd0;
      tick();
      idle_inputs();
      checks++; if (busy_o !== 32'h0000_0080) begin errors++; $display("FAIL sb_issue_v0 got=%h exp=00000080", busy_o); end
      alu_valid_i    = 1'b1;
      alu_vrd_addr_i = 5'd7;
      alu_vrd_data_i = DATA_C;
      #1;
      checks++; if (busy_o !== 32'h0000_0080) begin errors++; $display("FAIL sb_no_bypass got=%h exp=00000080", busy_o); end
      tick();
      idle_inputs();
      checks++; if (busy_o !== 32'h0) begin errors++; $display("FAIL sb_clear got=%h exp=0", busy_o); end
      checks++; if (vregw_en_o !== 1'b1 || vrd_addr_o !== 5'd7) begin errors++; $display("FAIL sb_write got en=%b addr=%0d exp en=1 addr=7", vregw_en_o, vrd_addr_o); end
      issue_valid_i    = 1'b1;
      issue_vrd_addr_i = 5'd7;
      tick();
      alu_valid_i    = 1'b1;
      alu_vrd_addr_i = 5'd7;
      alu_vrd_data_i = DATA_C;
      tick();
      idle_inputs();
      checks++; if (busy_o !== 32'h0000_0080) begin errors++; $display("FAIL sb_set_wins got=%h exp=00000080", busy_o); end
   endtask

   task automatic test_mid_reset();
      issue_valid_i    = 1'b1;
      issue_vrd_addr_i = 5'd9;
      alu_valid_i      = 1'b1;
      alu_vrd_addr_i   = 5'd9;
      alu_vrd_data_i   = DATA_B;
      tick();
      idle_inputs();
      checks++; if (vregw_en_o !== 1'b1 || vrd_addr_o !== 5'd9) begin errors++; $display("FAIL mr_write got en=%b addr=%0d exp en=1 addr=9", vregw_en_o, vrd_addr_o); end
      checks++; if (busy_o !== 32'h0000_0280) begin errors++; $display("FAIL mr_busy_pre got=%h exp=00000280", busy_o); end
      alu_valid_i = 1'b1;
      lsu_valid_i = 1'b1;
      rst = 1'b1;
      #1;
      checks++; if (vregw_en_o !== 1'b0) begin errors++; $display("FAIL mr_wen got=%b exp=0", vregw_en_o); end
      checks++; if (busy_o !== 32'h0) begin errors++; $display("FAIL mr_busy got=%h exp=0", busy_o); end
      checks++; if ({alu_ready_o, lsu_ready_o} !== 2'b00) begin errors++; $display("FAIL mr_ready got=%b exp=00", {alu_ready_o, lsu_ready_o}); end
      tick();
      rst = 1'b0;
      #1;
      checks++; if ({alu_ready_o, lsu_ready_o} !== 2'b10) begin errors++; $display("FAIL mr_pointer got=%b exp=10", {alu_ready_o, lsu_ready_o}); end
      tick();
      idle_inputs();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b1;
      idle_inputs();
      test_reset();
      test_single();
      test_v0();
      test_round_robin();
      test_scoreboard();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
